// File: rtl/out_display_pkg.sv
// Shared display definitions: seven-segment glyphs and the conversion FSM encoding.
package display_defs;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_e;

  // BCD nibble to active-high a..g pattern; non-decimal codes show blank.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NIBBLE_W-1:0] d);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/out_display_if.sv
// CPU OUT-port write channel into the display driver.
interface out_display_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             busy;

  modport master (output load, output data_in, input busy);
  modport slave  (input load, input data_in, output busy);
endinterface

// File: rtl/out_display_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift iteration per clock, the
// first one folded into the start cycle so the result lands after WIDTH cycles.
module bin2bcd #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned SH_W  = WIDTH + BCD_W;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [SH_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_bcd;
  logic [SH_W-1:0]  w_first;
  logic [SH_W-1:0]  w_step;

  function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] x);
    logic [SH_W-1:0] y;
    y = x;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (y[WIDTH+4*i +: 4] >= 4'd5) y[WIDTH+4*i +: 4] = y[WIDTH+4*i +: 4] + 4'd3;
    end
    return {y[SH_W-2:0], 1'b0};
  endfunction

  assign w_first = dabble({{BCD_W{1'b0}}, bin});
  assign w_step  = dabble(r_shift);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else if (start) begin
      r_shift <= w_first;
      r_cnt   <= CNT_W'(1);
      r_busy  <= 1'b1;
      r_done  <= (WIDTH == 1);
      if (WIDTH == 1) r_bcd <= w_first[SH_W-1 -: BCD_W];
    end else if (r_done) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_shift <= w_step;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_done <= 1'b1;
        r_bcd  <= w_step[SH_W-1 -: BCD_W];
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/out_display.sv
// OUT-port display driver: buffered binary-to-BCD conversion and a scanned
// 7-segment display. Define OUT_DISPLAY_SIGNED_EN for two's-complement values.
module out_display
  import display_defs::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  out_display_if.slave      bus,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int unsigned MAG_DIGITS = DIGITS - 1;
  localparam int unsigned BCD_W      = 4 * MAG_DIGITS;
  localparam int unsigned RF_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SC_W       = $clog2(DIGITS);

  conv_state_e       r_state, w_next_state;
  logic              w_start;
  logic [WIDTH-1:0]  w_src;
  logic [WIDTH-1:0]  w_mag;
  logic              w_sign;
  logic [WIDTH-1:0]  r_pend_val;
  logic              r_pend_vld;
  logic              r_conv_sign;
  logic [BCD_W-1:0]  r_disp_bcd;
  logic              r_disp_sign;
  logic              w_conv_busy;
  logic              w_done;
  logic [BCD_W-1:0]  w_bcd;
  logic [RF_W-1:0]   r_refresh;
  logic [SC_W-1:0]   r_scan;
  logic [MAG_DIGITS-1:0] w_keep;
  logic [SEG_W-1:0]  w_digit_seg;
  logic [DIGITS-1:0] w_sel;
  logic [SEG_W-1:0]  r_seg;
  logic [DIGITS-1:0] r_digit_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // A direct load beats the buffered value; the buffer is dropped either way.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_src        = bus.data_in;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_start      = 1'b1;
          w_next_state = ST_CONV;
        end else if (r_pend_vld) begin
          w_start      = 1'b1;
          w_src        = r_pend_val;
          w_next_state = ST_CONV;
        end
      end
      ST_CONV: if (w_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

`ifdef OUT_DISPLAY_SIGNED_EN
  assign w_sign = w_src[WIDTH-1];
  assign w_mag  = w_sign ? (~w_src + WIDTH'(1)) : w_src;
`else
  assign w_sign = 1'b0;
  assign w_mag  = w_src;
`endif

  bin2bcd #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (MAG_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (w_mag),
    .busy  (w_conv_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign bus.busy = w_conv_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_vld <= 1'b0;
    end else if (r_state == ST_CONV && bus.load) begin
      r_pend_val <= bus.data_in;
      r_pend_vld <= 1'b1;
    end else if (w_start) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Result and sign swap in together so the scan never shows a mixed value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conv_sign <= 1'b0;
      r_disp_bcd  <= '0;
      r_disp_sign <= 1'b0;
    end else begin
      if (w_start) r_conv_sign <= w_sign;
      if (w_done) begin
        r_disp_bcd  <= w_bcd;
        r_disp_sign <= r_conv_sign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_scan    <= '0;
    end else if (r_refresh == RF_W'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_scan    <= (r_scan == SC_W'(DIGITS - 1)) ? '0 : r_scan + SC_W'(1);
    end else begin
      r_refresh <= r_refresh + RF_W'(1);
    end
  end

  // Leading-zero blanking: a digit is shown if it or any higher magnitude digit is nonzero.
  always_comb begin
    logic v_nz;
    v_nz   = 1'b0;
    w_keep = '0;
    for (int i = int'(MAG_DIGITS) - 1; i >= 0; i--) begin
      v_nz      = v_nz | (r_disp_bcd[4*i +: 4] != 4'd0);
      w_keep[i] = v_nz;
    end
    w_keep[0] = 1'b1;
  end

  always_comb begin
    w_digit_seg = SEG_BLANK;
    w_sel       = '0;
    if (r_scan == SC_W'(DIGITS - 1)) w_digit_seg = r_disp_sign ? SEG_MINUS : SEG_BLANK;
    for (int i = 0; i < int'(MAG_DIGITS); i++) begin
      if (r_scan == SC_W'(i) && w_keep[i]) w_digit_seg = seg_encode(r_disp_bcd[4*i +: 4]);
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_scan == SC_W'(i)) w_sel[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg       <= SEG_BLANK;
      r_digit_sel <= '0;
    end else begin
      r_seg       <= w_digit_seg;
      r_digit_sel <= w_sel;
    end
  end

  assign seg       = r_seg;
  assign digit_sel = r_digit_sel;

endmodule
